// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: FSM state encoding, funct3 codes and byte-lane masks.
package rv32i_pkg;

    localparam logic [2:0] LSU_IDLE      = 3'd0;
    localparam logic [2:0] LSU_PARK      = 3'd1;
    localparam logic [2:0] LSU_ISSUE     = 3'd2;
    localparam logic [2:0] LSU_WAIT_LOW  = 3'd3;
    localparam logic [2:0] LSU_WAIT_HIGH = 3'd4;
    localparam logic [2:0] LSU_RESP      = 3'd5;

    typedef enum logic [2:0] {
        StIdle     = LSU_IDLE,
        StPark     = LSU_PARK,
        StIssue    = LSU_ISSUE,
        StWaitLow  = LSU_WAIT_LOW,
        StWaitHigh = LSU_WAIT_HIGH,
        StResp     = LSU_RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] OP_BYTE = 4'b0001;
    localparam logic [3:0] OP_HALF = 4'b0011;
    localparam logic [3:0] OP_WORD = 4'b1111;

    // Byte-lane mask for an access width; only called for legal funct3 values.
    function automatic logic [3:0] mem_op_for(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return OP_BYTE;
            F3_H, F3_HU: return OP_HALF;
            default:     return OP_WORD;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Extracts the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
    import rv32i_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    // Width/sign selection; stores and unknown codes yield zero.
    always_comb begin
        data = 32'd0;
        if (!is_store) begin
            case (funct3)
                F3_B:    data = {{24{rdata[7]}}, rdata[7:0]};
                F3_BU:   data = {24'd0, rdata[7:0]};
                F3_H:    data = {{16{rdata[15]}}, rdata[15:0]};
                F3_HU:   data = {16'd0, rdata[15:0]};
                F3_W:    data = rdata;
                default: data = 32'd0;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, handshaking with a data memory that
// signals completion by dropping and re-raising mem_data_valid.
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           store_data,
    output logic                  resp_valid,
    output logic [31:0]           load_data,
    output logic                  fault,
    output logic                  mem_we,
    output logic [3:0]            mem_op,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_data_valid,
    input  logic [31:0]           mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    lsu_state_e            state_q;
    logic                  store_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [ADDR_WIDTH-1:0] trk_addr_q;
    logic                  trk_valid_q;
    logic                  park_low_q;

    logic                  acc_fault;
    logic                  acc_park;
    logic                  f3_ok;
    logic                  iss_store;
    logic [2:0]            iss_f3;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic [31:0]           iss_wdata;
    logic [31:0]           ext_data;

    load_extend u_load_extend (
        .is_store (store_q),
        .funct3   (f3_q),
        .rdata    (mem_rdata),
        .data     (ext_data)
    );

    // Classify the incoming request: rejected outright, or needs a park first.
    always_comb begin
        case (funct3)
            F3_B, F3_H, F3_W: f3_ok = 1'b1;
            F3_BU, F3_HU:     f3_ok = !is_store;
            default:          f3_ok = 1'b0;
        endcase
        acc_fault = !f3_ok
                    || (funct3[1:0] == 2'b01 && addr[0])
                    || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
                    || ((addr >> ADDR_WIDTH) != 32'd0);
        // Re-accessing the tracked address would not change the memory inputs, so the
        // memory would never drop valid; parking on a neighbour forces a fresh handshake.
        acc_park  = !trk_valid_q || (addr[ADDR_WIDTH-1:0] == trk_addr_q);
    end

    // Issue fields come straight from the inputs on accept, from the latches after a park.
    always_comb begin
        if (state_q == StIdle) begin
            iss_store = is_store;
            iss_f3    = funct3;
            iss_addr  = addr[ADDR_WIDTH-1:0];
            iss_wdata = store_data;
        end else begin
            iss_store = store_q;
            iss_f3    = f3_q;
            iss_addr  = addr_q;
            iss_wdata = wdata_q;
        end
    end

    // Control FSM with registered outputs; entering a state sets the outputs it drives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            fault       <= 1'b0;
            load_data   <= 32'd0;
            mem_we      <= 1'b0;
            mem_op      <= 4'b0000;
            mem_addr    <= '0;
            mem_wdata   <= 32'd0;
            store_q     <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            trk_addr_q  <= '0;
            trk_valid_q <= 1'b0;
            park_low_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        store_q   <= is_store;
                        f3_q      <= funct3;
                        addr_q    <= addr[ADDR_WIDTH-1:0];
                        wdata_q   <= store_data;
                        req_ready <= 1'b0;
                        if (acc_fault) begin
                            fault      <= 1'b1;
                            resp_valid <= 1'b1;
                            load_data  <= 32'd0;
                            state_q    <= StResp;
                        end else if (acc_park) begin
                            mem_addr   <= addr[ADDR_WIDTH-1:0] ^ ADDR_ONE;
                            mem_we     <= 1'b0;
                            park_low_q <= 1'b0;
                            state_q    <= StPark;
                        end else begin
                            mem_addr    <= iss_addr;
                            mem_op      <= mem_op_for(iss_f3);
                            mem_wdata   <= iss_wdata;
                            mem_we      <= iss_store;
                            trk_addr_q  <= iss_addr;
                            trk_valid_q <= 1'b1;
                            state_q     <= StIssue;
                        end
                    end
                end
                StPark: begin
                    if (!park_low_q) begin
                        if (!mem_data_valid) park_low_q <= 1'b1;
                    end else if (mem_data_valid) begin
                        mem_addr    <= iss_addr;
                        mem_op      <= mem_op_for(iss_f3);
                        mem_wdata   <= iss_wdata;
                        mem_we      <= iss_store;
                        trk_addr_q  <= iss_addr;
                        trk_valid_q <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: state_q <= StWaitLow;
                StWaitLow: begin
                    if (!mem_data_valid) state_q <= StWaitHigh;
                end
                StWaitHigh: begin
                    if (mem_data_valid) begin
                        resp_valid <= 1'b1;
                        fault      <= 1'b0;
                        load_data  <= ext_data;
                        mem_we     <= 1'b0;
                        state_q    <= StResp;
                    end
                end
                StResp: begin
                    resp_valid <= 1'b0;
                    fault      <= 1'b0;
                    req_ready  <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural byte memory and a response scoreboard.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        fault;
    logic        mem_we;
    logic [3:0]  mem_op;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_data_valid = 1'b1;
    logic [31:0] mem_rdata = 32'd0;

    load_store_unit #(.ADDR_WIDTH(12)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .is_store       (is_store),
        .funct3         (funct3),
        .addr           (addr),
        .store_data     (store_data),
        .resp_valid     (resp_valid),
        .load_data      (load_data),
        .fault          (fault),
        .mem_we         (mem_we),
        .mem_op         (mem_op),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_data_valid (mem_data_valid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        f;
        logic [31:0] d;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          acc_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          resp_cnt = 0;
    logic        we_seen = 1'b0;
    logic        park_seen = 1'b0;
    logic [11:0] park_tgt = 12'hFFF;

    // Memory: any change of its inputs drops valid, the access lands 3 cycles later.
    logic [7:0]  mem [0:4095];
    logic [11:0] last_addr = 12'd0;
    logic        last_we = 1'b0;
    logic [3:0]  last_op = 4'd0;
    logic [31:0] last_wdata = 32'd0;
    int          mcnt = 0;

    always @(posedge clk) begin
        if (mem_addr !== last_addr || mem_we !== last_we || mem_op !== last_op
            || mem_wdata !== last_wdata) begin
            last_addr      <= mem_addr;
            last_we        <= mem_we;
            last_op        <= mem_op;
            last_wdata     <= mem_wdata;
            mem_data_valid <= 1'b0;
            mcnt           <= 2;
        end else if (!mem_data_valid) begin
            if (mcnt == 0) begin
                if (mem_we)
                    for (int i = 0; i < 4; i++)
                        if (mem_op[i]) mem[mem_addr + 12'(i)] <= mem_wdata[8*i +: 8];
                mem_rdata <= {mem[mem_addr + 12'd3], mem[mem_addr + 12'd2],
                              mem[mem_addr + 12'd1], mem[mem_addr]};
                mem_data_valid <= 1'b1;
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Record accept cycles for latency measurement.
    always @(posedge clk) begin
        if (!reset && req_valid && req_ready) begin
            acc_q.push_back(cyc);
            acc_cnt <= acc_cnt + 1;
        end
        if (mem_addr == park_tgt && !mem_we) park_seen <= 1'b1;
    end

    // Response checker: pop the scoreboard on every resp_valid pulse.
    always @(negedge clk) begin
        if (mem_we) we_seen <= 1'b1;
        if (resp_valid) begin
            resp_cnt <= resp_cnt + 1;
            check("resp_expected", 32'(sb.size() > 0 && acc_q.size() > 0), 32'd1);
            if (sb.size() > 0 && acc_q.size() > 0) begin
                exp_t e;
                int   lat;
                e   = sb.pop_front();
                lat = cyc - acc_q.pop_front();
                check({e.tag, "_fault"}, {31'd0, fault}, {31'd0, e.f});
                check({e.tag, "_data"}, load_data, e.d);
                if (e.f) check({e.tag, "_lat"}, lat, 32'd1);
                else     check({e.tag, "_lat_ge4"}, 32'(lat >= 4), 32'd1);
            end
        end
    end

    // Present one request (called at a negedge) and return at the negedge after accept.
    task automatic send(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic ef, input logic [31:0] ed, input bit hold);
        exp_t e;
        int   n = 0;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = d;
        req_valid  = 1'b1;
        e.f = ef;
        e.d = ed;
        e.tag = tag;
        sb.push_back(e);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({tag, "_accept_timeout"}, {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
        end else begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, sb.size(), 32'd0);
    endtask

    initial begin
        logic [11:0] addr_before;
        int          r0;
        int          a0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'd0;
        reset = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        addr = 32'd0; store_data = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_op", {28'd0, mem_op}, 32'd0);
        check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Store then load the same word: the load must park.
        send("sw_010", 1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0);
        drain("sw_010");
        park_tgt = 12'h011; park_seen = 1'b0;
        send("lw_010", 1'b0, 3'b010, 32'h010, 32'd0, 1'b0, 32'hDEADBEEF, 1'b0);
        drain("lw_010");
        check("lw_010_parked", {31'd0, park_seen}, 32'd1);

        // Byte store, signed and unsigned byte loads.
        send("sb_021", 1'b1, 3'b000, 32'h021, 32'h00000080, 1'b0, 32'd0, 1'b0);
        drain("sb_021");
        send("lb_021", 1'b0, 3'b000, 32'h021, 32'd0, 1'b0, 32'hFFFFFF80, 1'b0);
        drain("lb_021");
        send("lbu_021", 1'b0, 3'b100, 32'h021, 32'd0, 1'b0, 32'h00000080, 1'b0);
        drain("lbu_021");

        // Misaligned half: fault without touching memory.
        addr_before = mem_addr; we_seen = 1'b0;
        send("lh_013", 1'b0, 3'b001, 32'h013, 32'd0, 1'b1, 32'd0, 1'b0);
        drain("lh_013");
        check("lh_013_mem_addr", {20'd0, mem_addr}, {20'd0, addr_before});
        check("lh_013_no_we", {31'd0, we_seen}, 32'd0);

        send("ld_f3_011", 1'b0, 3'b011, 32'h020, 32'd0, 1'b1, 32'd0, 1'b0);
        drain("ld_f3_011");
        send("lw_1000", 1'b0, 3'b010, 32'h00001000, 32'd0, 1'b1, 32'd0, 1'b0);
        drain("lw_1000");

        // Three requests with req_valid held high throughout.
        r0 = resp_cnt; a0 = acc_cnt;
        send("b2b_sw", 1'b1, 3'b010, 32'h100, 32'h8899AABB, 1'b0, 32'd0, 1'b1);
        send("b2b_lh", 1'b0, 3'b001, 32'h102, 32'd0, 1'b0, 32'hFFFF8899, 1'b1);
        send("b2b_lw", 1'b0, 3'b010, 32'h100, 32'd0, 1'b0, 32'h8899AABB, 1'b0);
        drain("b2b");
        repeat (4) @(negedge clk);
        check("b2b_resp_count", resp_cnt - r0, 32'd3);
        check("b2b_accept_count", acc_cnt - a0, 32'd3);

        // Reset while a store waits for the memory.
        send("sw_040", 1'b1, 3'b010, 32'h040, 32'hCAFEF00D, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        check("sw_040_we_before_rst", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("midrst_mem_addr", {20'd0, mem_addr}, 32'd0);
        sb.delete();
        acc_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        park_tgt = 12'h041; park_seen = 1'b0;
        send("lw_040", 1'b0, 3'b010, 32'h040, 32'd0, 1'b0, 32'd0, 1'b0);
        drain("lw_040");
        check("lw_040_parked", {31'd0, park_seen}, 32'd1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
